// File: rtl/jtcps1_starfield_if.sv
// Shared star ROM port between the star field generator and the SDRAM/ROM arbiter.
interface jtcps1_starfield_if #(
  parameter int LW = 1
);
  logic [LW+12:0] rom_addr;
  logic [31:0]    rom_data;
  logic           rom_ok;
  logic           rom_cs;

  modport master (output rom_addr, rom_cs, input rom_data, rom_ok);
  modport slave  (input rom_addr, rom_cs, output rom_data, rom_ok);
endinterface

// File: rtl/jtcps1_starfield.sv
// Multi-layer CPS star field: per-line cache fill from one shared ROM port,
// then per-layer star pixel generation with a shared blink counter pair.
module jtcps1_starfield #(
  parameter int         LAYERS  = 2,
  parameter int         LW      = 1,
  parameter int         FDIV    = 16,
  parameter logic [8:0] HOFFSET = 9'd0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pxl_cen,
  input  logic                  HS,
  input  logic                  VB,
  input  logic                  flip,
  input  logic [8:0]            hdump,
  input  logic [8:0]            vdump,
  input  logic [9*LAYERS-1:0]   hpos,
  input  logic [9*LAYERS-1:0]   vpos,
  input  logic [LAYERS-1:0]     enable,
  jtcps1_starfield_if.master    rom,
  output logic [7*LAYERS-1:0]   pxl
);
  localparam int FW = $clog2(FDIV);

  typedef enum logic {IDLE, FILL} state_t;

  state_t         state_reg, state_next;
  logic [LW-1:0]  layer_reg, layer_next, first_layer, next_layer;
  logic [3:0]     k_reg, k_next;
  logic           first_found, next_found, clr_valid, wr_en;
  logic           hs_l_reg, vb_l_reg, hs_fall;
  logic [FW-1:0]  frame_reg;
  logic [3:0]     cnt15_reg, cnt16_reg;
  logic [8:0]     hpos_a [LAYERS];
  logic [8:0]     veff_a [LAYERS];
  logic [3:0]     col;

  assign hs_fall = hs_l_reg & ~HS;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_l_reg  <= 1'b0;
      vb_l_reg  <= 1'b0;
      frame_reg <= '0;
      cnt15_reg <= 4'd0;
      cnt16_reg <= 4'd0;
      state_reg <= IDLE;
      layer_reg <= '0;
      k_reg     <= 4'd0;
    end else if (pxl_cen) begin
      hs_l_reg  <= HS;
      vb_l_reg  <= VB;
      state_reg <= state_next;
      layer_reg <= layer_next;
      k_reg     <= k_next;
      if (VB && !vb_l_reg) frame_reg <= frame_reg + 1'b1;
      // Blink steps only during the last frame of each FDIV-frame period
      if (&frame_reg) begin
        cnt16_reg <= cnt16_reg + 4'd1;
        cnt15_reg <= (cnt15_reg == 4'd14) ? 4'd0 : cnt15_reg + 4'd1;
      end
    end
  end

  always_comb begin
    first_found = 1'b0;
    first_layer = '0;
    next_found  = 1'b0;
    next_layer  = '0;
    for (int i = 0; i < LAYERS; i++) begin
      if (!first_found && enable[i]) begin
        first_found = 1'b1;
        first_layer = LW'(i);
      end
      if (!next_found && enable[i] && i > int'(layer_reg)) begin
        next_found = 1'b1;
        next_layer = LW'(i);
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    layer_next = layer_reg;
    k_next     = k_reg;
    clr_valid  = 1'b0;
    wr_en      = 1'b0;
    if (pxl_cen) begin
      // An HS edge always restarts the fill, discarding a partial line
      if (hs_fall) begin
        clr_valid = 1'b1;
        k_next    = 4'd0;
        if (first_found) begin
          state_next = FILL;
          layer_next = first_layer;
        end else begin
          state_next = IDLE;
        end
      end else if (state_reg == FILL && rom.rom_ok) begin
        wr_en = 1'b1;
        if (k_reg != 4'd15) begin
          k_next = k_reg + 4'd1;
        end else begin
          k_next = 4'd0;
          if (next_found) layer_next = next_layer;
          else            state_next = IDLE;
        end
      end
    end
  end

  assign col          = ~((~hpos_a[layer_reg][8:5] + k_reg + 4'd2) ^ {4{flip}});
  assign rom.rom_cs   = (state_reg == FILL);
  assign rom.rom_addr = {layer_reg, col, veff_a[layer_reg]};

  for (genvar gi = 0; gi < LAYERS; gi++) begin : g_layer
    logic [7:0]  cache [16];
    logic [15:0] valid_reg;
    logic [8:0]  veff_reg;
    logic [7:0]  sd_reg;
    logic        v_reg;
    logic [8:0]  heff;
    logic [4:0]  pos;
    logic        hit;
    logic [3:0]  colour;
    logic [6:0]  pxl_reg;

    assign hpos_a[gi] = hpos[9*gi +: 9];
    assign veff_a[gi] = veff_reg;
    assign heff       = (hpos_a[gi] + hdump - HOFFSET) ^ {9{flip}};
    assign pos        = sd_reg[4:0] ^ {5{flip}};
    assign hit        = v_reg && (pos == heff[4:0]) && (pos != 5'h0F);
    assign colour     = sd_reg[7] ? cnt15_reg : cnt16_reg;
    assign pxl[7*gi +: 7] = pxl_reg;

    always_ff @(posedge clk) begin
      if (wr_en && layer_reg == LW'(gi)) cache[k_reg] <= rom.rom_data[7:0];
      sd_reg <= cache[heff[8:5]];
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_reg <= 16'd0;
        veff_reg  <= 9'd0;
        v_reg     <= 1'b0;
        pxl_reg   <= 7'h0F;
      end else begin
        v_reg <= valid_reg[heff[8:5]];
        if (pxl_cen) begin
          veff_reg <= (vpos[9*gi +: 9] + vdump) ^ {9{flip}};
          if (clr_valid)
            valid_reg <= 16'd0;
          else if (wr_en && layer_reg == LW'(gi))
            valid_reg[k_reg] <= 1'b1;
          pxl_reg <= enable[gi] ? {sd_reg[7:5], hit ? colour : 4'hF} : 7'h0F;
        end
      end
    end
  end
endmodule

// File: tb/tb_jtcps1_starfield.sv
// Directed bench for jtcps1_starfield: fill order, star hits, reset, enables, abort and blink.
module tb_jtcps1_starfield;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pxl_cen = 1'b1;
  logic        HS = 1'b0;
  logic        VB = 1'b0;
  logic        flip = 1'b0;
  logic [8:0]  hdump = 9'd3;
  logic [8:0]  vdump = 9'h010;
  logic [17:0] hpos = 18'd0;
  logic [17:0] vpos = {9'd5, 9'd0};
  logic [1:0]  enable = 2'b11;
  logic [13:0] pxl;
  logic [7:0]  star0 = 8'hA3;
  logic [7:0]  star1 = 8'h23;
  int          n_cmp = 0;
  int          n_err = 0;

  jtcps1_starfield_if #(.LW(1)) rom_bus ();

  // ROM model: every word of layer 0 holds star0, every word of layer 1 holds star1
  assign rom_bus.rom_data = {24'd0, rom_bus.rom_addr[13] ? star1 : star0};

  jtcps1_starfield #(.LAYERS(2), .LW(1), .FDIV(2), .HOFFSET(9'd0)) dut (
    .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .HS(HS), .VB(VB), .flip(flip),
    .hdump(hdump), .vdump(vdump), .hpos(hpos), .vpos(vpos), .enable(enable),
    .rom(rom_bus), .pxl(pxl)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic hs_pulse();
    HS = 1'b1;
    tick(1);
    HS = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    tick(2);
    for (int i = 0; i < 200 && rom_bus.rom_cs; i++) tick(1);
    check_val(tag, {31'd0, rom_bus.rom_cs}, 32'd0);
  endtask

  // hpos=0, flip=0: column = ~(~0 + k + 2) = ~(k + 1); veff = vpos + 0x10
  function automatic logic [13:0] exp_addr(input int l, input int k);
    logic [3:0] c;
    c = ~(4'(k) + 4'd1);
    return {l[0], c, (l != 0) ? 9'h015 : 9'h010};
  endfunction

  initial begin
    rom_bus.rom_ok = 1'b1;
    tick(1);
    check_val("rst_cs", {31'd0, rom_bus.rom_cs}, 32'd0);
    check_val("rst_pxl", {18'd0, pxl}, 32'h078F);
    tick(1);
    rst = 1'b0;
    tick(5);
    check_val("idle_cs", {31'd0, rom_bus.rom_cs}, 32'd0);

    // Fill order: 16 beats layer 0 then 16 beats layer 1
    hs_pulse();
    for (int n = 0; n < 32; n++) begin
      tick(1);
      check_val($sformatf("addr%0d", n), {18'd0, rom_bus.rom_addr}, {18'd0, exp_addr(n / 16, n % 16)});
    end
    tick(1);
    check_val("fill_end_cs", {31'd0, rom_bus.rom_cs}, 32'd0);

    // Star hits
    tick(3);
    check_val("hit0", {25'd0, pxl[6:0]}, 32'h50);
    check_val("hit1", {25'd0, pxl[13:7]}, 32'h10);
    hdump = 9'd4;
    tick(3);
    check_val("miss0", {25'd0, pxl[6:0]}, 32'h5F);
    check_val("miss1", {25'd0, pxl[13:7]}, 32'h1F);

    // pos == 0x0F never lights, even when it matches heff
    star0 = 8'h2F;
    hs_pulse();
    wait_idle("fill2f_done");
    hdump = 9'd15;
    tick(3);
    check_val("pos0f", {25'd0, pxl[6:0]}, 32'h1F);
    star0 = 8'hA3;
    hdump = 9'd3;

    // Reset in the middle of a fill (k = 7)
    hs_pulse();
    tick(8);
    rst = 1'b1;
    #1;
    check_val("midrst_cs", {31'd0, rom_bus.rom_cs}, 32'd0);
    check_val("midrst_pxl", {18'd0, pxl}, 32'h078F);
    tick(1);
    rst = 1'b0;
    tick(10);
    check_val("postrst_cs", {31'd0, rom_bus.rom_cs}, 32'd0);
    check_val("postrst_inval", {25'd0, pxl[6:0]}, 32'h5F);

    // Only layer 1 enabled
    enable = 2'b10;
    hs_pulse();
    for (int n = 0; n < 16; n++) begin
      tick(1);
      check_val($sformatf("en10_addr%0d", n), {18'd0, rom_bus.rom_addr}, {18'd0, exp_addr(1, n)});
    end
    tick(1);
    check_val("en10_cs", {31'd0, rom_bus.rom_cs}, 32'd0);
    tick(3);
    check_val("en10_pxl0", {25'd0, pxl[6:0]}, 32'h0F);
    check_val("en10_pxl1", {25'd0, pxl[13:7]}, 32'h10);

    // Dropping enable[1] mid-layer still completes that layer
    enable = 2'b11;
    hs_pulse();
    for (int n = 0; n < 32; n++) begin
      tick(1);
      check_val($sformatf("tog_addr%0d", n), {18'd0, rom_bus.rom_addr}, {18'd0, exp_addr(n / 16, n % 16)});
      if (n == 20) enable = 2'b01;
    end
    tick(1);
    check_val("tog_cs", {31'd0, rom_bus.rom_cs}, 32'd0);
    tick(3);
    check_val("tog_pxl1", {25'd0, pxl[13:7]}, 32'h0F);
    enable = 2'b11;

    // Abort: ROM never ready over 20 lines
    rom_bus.rom_ok = 1'b0;
    repeat (20) begin
      hs_pulse();
      tick(3);
    end
    check_val("abort_cs", {31'd0, rom_bus.rom_cs}, 32'd1);
    check_val("abort_col0", {28'd0, pxl[3:0]}, 32'hF);
    check_val("abort_col1", {28'd0, pxl[10:7]}, 32'hF);
    rom_bus.rom_ok = 1'b1;
    wait_idle("abort_done");
    tick(3);
    check_val("abort_hit0", {25'd0, pxl[6:0]}, 32'h50);
    check_val("abort_hit1", {25'd0, pxl[13:7]}, 32'h10);

    // Blink with FDIV=2: one VB rise makes the frame counter all-ones
    VB = 1'b1;
    for (int j = 0; j <= 20; j++) begin
      int e15, e16;
      logic [6:0] w0, w1;
      tick(1);
      e15 = (j < 2) ? 0 : (j - 1) % 15;
      e16 = (j < 2) ? 0 : (j - 1) % 16;
      w0 = {3'd5, 4'(e15)};
      w1 = {3'd1, 4'(e16)};
      check_val($sformatf("blink15_%0d", j), {25'd0, pxl[6:0]}, {25'd0, w0});
      check_val($sformatf("blink16_%0d", j), {25'd0, pxl[13:7]}, {25'd0, w1});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
